// File: rtl/fft8_pkg.sv
// Shared constants, loader state encoding and bit-reversal helper for the 8-point FFT.
package fft8_pkg;

  localparam int unsigned FFT8_N  = 8;
  localparam int unsigned FFT8_AW = 3;

  typedef enum logic [1:0] {
    StFill     = 2'b00,
    StStart    = 2'b01,
    StWaitDone = 2'b10
  } loader_state_e;

  // Mirror the three address bits: 1->4, 3->6, etc.
  function automatic logic [FFT8_AW-1:0] bitrev3(input logic [FFT8_AW-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft_input_loader_8pt_if.sv
// Stream input, buffer write port, FFT handshake and status of the input loader.
interface fft_input_loader_8pt_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FCNT_W = 16
);
  import fft8_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_re;
  logic [DATA_W-1:0]    s_im;
  logic                 s_last;
  logic                 buf_wr_en;
  logic [FFT8_AW-1:0]   buf_wr_addr;
  logic [DATA_W-1:0]    buf_wr_re;
  logic [DATA_W-1:0]    buf_wr_im;
  logic                 fft_start;
  logic                 fft_done;
  logic                 loader_busy;
  logic                 frame_err;
  logic [FCNT_W-1:0]    frame_cnt;

  // Loader view: consumes the stream, drives buffer and status.
  modport slave (
    input  s_valid, s_re, s_im, s_last, fft_done,
    output s_ready, buf_wr_en, buf_wr_addr, buf_wr_re, buf_wr_im,
           fft_start, loader_busy, frame_err, frame_cnt
  );

  // Environment view: sample source plus FFT control.
  modport master (
    output s_valid, s_re, s_im, s_last, fft_done,
    input  s_ready, buf_wr_en, buf_wr_addr, buf_wr_re, buf_wr_im,
           fft_start, loader_busy, frame_err, frame_cnt
  );

endinterface

// File: rtl/fft_bitrev_addr.sv
// Maps a sample index to a buffer address, bit-reversed or natural order.
module fft_bitrev_addr
  import fft8_pkg::*;
#(
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic [FFT8_AW-1:0] idx_i,
  output logic [FFT8_AW-1:0] addr_o
);

  // Pure mapping, selected at elaboration time.
  always_comb begin
    addr_o = BIT_REVERSE ? bitrev3(idx_i) : idx_i;
  end

endmodule

// File: rtl/fft_input_loader_8pt.sv
// Loads 8-sample frames into the FFT buffer, starts the FFT and waits for done.
module fft_input_loader_8pt
  import fft8_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter bit          BIT_REVERSE = 1'b1,
  parameter int unsigned FCNT_W      = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  fft_input_loader_8pt_if.slave    bus
);

  loader_state_e        state_q, state_d;
  logic [FFT8_AW-1:0]   count_q, count_d;
  logic                 wr_en_q, wr_en_d;
  logic [FFT8_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_re_q, wr_re_d;
  logic [DATA_W-1:0]    wr_im_q, wr_im_d;
  logic                 err_q, err_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic [FFT8_AW-1:0]   map_addr;
  logic                 accept;

  fft_bitrev_addr #(
    .BIT_REVERSE (BIT_REVERSE)
  ) u_addr_map (
    .idx_i  (count_q),
    .addr_o (map_addr)
  );

  // Ready depends on state only; gated by reset so it reads low while held in reset.
  always_comb begin
    bus.s_ready     = rst_n && (state_q == StFill);
    bus.loader_busy = (state_q != StFill);
    bus.fft_start   = (state_q == StStart);
    bus.buf_wr_en   = wr_en_q;
    bus.buf_wr_addr = wr_addr_q;
    bus.buf_wr_re   = wr_re_q;
    bus.buf_wr_im   = wr_im_q;
    bus.frame_err   = err_q;
    bus.frame_cnt   = fcnt_q;
    accept          = bus.s_valid && bus.s_ready;
  end

  // Next-state: accept samples in FILL, one START cycle, then wait for fft_done.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_re_d   = wr_re_q;
    wr_im_d   = wr_im_q;
    err_d     = 1'b0;
    fcnt_d    = fcnt_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = map_addr;
          wr_re_d   = bus.s_re;
          wr_im_d   = bus.s_im;
          if (count_q == 3'(FFT8_N - 1)) begin
            // Frame is started even without s_last; the missing marker is flagged.
            state_d = StStart;
            count_d = '0;
            err_d   = !bus.s_last;
          end else if (bus.s_last) begin
            // Early s_last abandons the partial frame.
            count_d = '0;
            err_d   = 1'b1;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      StStart: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.fft_done) begin
          fcnt_d  = fcnt_q + 1'b1;
          count_d = '0;
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_re_q   <= '0;
      wr_im_q   <= '0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_re_q   <= wr_re_d;
      wr_im_q   <= wr_im_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
    end
  end

endmodule

// File: doc/fft_input_loader_8pt.md
Name: fft_input_loader_8pt

Overview:
- Upstream feeder for the 8-point radix-2 FFT control/datapath.
- Accepts a valid/ready stream of complex samples, eight per frame, and writes them into the shared FFT buffer in bit-reversed order.
- After the eighth sample it pulses fft_start, then holds off input until the FFT control reports done.
- Tracks framing errors and counts completed frames.

Parameters:
- DATA_W, 16, width of each real/imag component (two's complement).
- BIT_REVERSE, 1, 1 = bit-reversed buffer addressing; 0 = natural order.
- FCNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  loader can accept a sample
- s_re  in  DATA_W  sample real part
- s_im  in  DATA_W  sample imag part
- s_last  in  1  marks the final (8th) sample of a frame
- buf_wr_en  out  1  buffer write strobe (registered)
- buf_wr_addr  out  3  buffer write address (registered)
- buf_wr_re  out  DATA_W  buffer write data, real (registered)
- buf_wr_im  out  DATA_W  buffer write data, imag (registered)
- fft_start  out  1  one-cycle start pulse to FFT control
- fft_done  in  1  one-cycle done pulse from FFT control
- loader_busy  out  1  high whenever state is not FILL
- frame_err  out  1  one-cycle pulse on a framing violation
- frame_cnt  out  FCNT_W  number of frames handed to the FFT that completed (wraps)

Behaviour:
- Reset values:
  - state FILL, sample count 0
  - s_ready 0 during reset; 1 in the first cycle after reset release (combinational from state)
  - buf_wr_en 0, buf_wr_addr 0, buf_wr_re 0, buf_wr_im 0
  - fft_start 0, frame_err 0, frame_cnt 0
  - loader_busy 0
- States:
  - FILL: s_ready=1.
    - Accept when s_valid && s_ready.
    - Next cycle: buf_wr_en=1, buf_wr_addr=bitrev(count) (or count if BIT_REVERSE=0), data = accepted sample. Latency is 1 cycle.
    - bitrev map: 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
    - count increments per accept.
  - START: entered on the cycle after the 8th accept (count==7 at accept).
    - s_ready=0. fft_start=1 for exactly this cycle.
    - The final buffer write (buf_wr_en=1) also occurs this cycle; the buffer commits it at the same edge at which control samples start.
    - Go to WAIT_DONE.
  - WAIT_DONE: s_ready=0, buf_wr_en=0.
    - On fft_done: frame_cnt increments (wrap at 2^FCNT_W), count←0, go to FILL. s_ready rises the following cycle.
- Framing rules:
  - s_last accepted with count<7: that sample is written; frame_err pulses next cycle; count←0; stay FILL, no fft_start. The partial frame is abandoned, and later writes overwrite it.
  - 8th accept with s_last=0: frame_err pulses next cycle; frame is still started normally.
  - s_valid while s_ready=0: ignored; upstream must hold data.
- fft_done in FILL or START: ignored, no counter change.
- Reset mid-frame or mid-FFT: immediately returns to reset values. The partially written buffer is don't-care.
- No combinational path from s_valid to s_ready.
- Throughput:
  - 8 accept cycles, then 1 START cycle, then the FFT duration, then 1 cycle before the next accept.
  - Back-to-back valid in FILL gives 1 sample per cycle.

Decomposition:
- Shared package fft8_pkg:
  - FFT8_N=8, FFT8_AW=3
  - bitrev3 function/constant table
  - loader state encoding: FILL=2'b00, START=2'b01, WAIT_DONE=2'b10
- One natural sub-module: fft_bitrev_addr (3-bit combinational address mapper with BIT_REVERSE select), reusable by the output unloader.
- Everything else lives in the top FSM.

Test Plan:
- Reset release, stream samples re=k, im=-k for k=0..7 back-to-back with s_last on k=7:
  - writes appear one cycle after each accept at addresses 0,4,2,6,1,5,3,7 with matching data
  - fft_start is high once, in the cycle of the addr-7 write
  - s_ready=0 from that cycle
- Hold in WAIT_DONE for 40 cycles with s_valid=1:
  - no accepts, no writes
  - pulse fft_done → frame_cnt=1, s_ready=1 on the next cycle
- Early s_last on the 5th sample (count=4):
  - write to addr 1 occurs, frame_err pulses once, no fft_start
  - the next 8 samples form a clean frame starting at addr 0
- 8th sample without s_last: frame_err pulses, fft_start still pulses, frame_cnt increments after fft_done.
- BIT_REVERSE=0, random s_valid gaps (about 50% duty): addresses 0..7 in order, data matches accepts, start fires after exactly 8 accepts.
- Assert rst_n low after 3 accepts:
  - all outputs return to reset values
  - the next frame writes from addr 0, frame_cnt stays 0
- Also check that a stray fft_done in FILL is ignored.
